// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Define MC_ORI_EN to add ori support (states ORIEX=12, ORIWB=13).
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode_i,
    input  logic       Zero_i,
    output logic       MemWrite_o,
    output logic       IorD_o,
    output logic       IRWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic [1:0] PCSrc_o,
    output logic       PCEn_o,
    output logic       Illegal_o,
    output logic [3:0] State_o
);

`ifdef MC_ORI_EN
    localparam logic [5:0] OP_ORI = 6'h0D;
`endif

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
`ifdef MC_ORI_EN
        S_ORIEX    = 4'd12,
        S_ORIWB    = 4'd13,
`endif
        S_JUMP     = 4'd11
    } state_t;

    state_t state_q, state_d;
    logic   pc_write, branch;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        MemWrite_o = 1'b0;
        IorD_o     = 1'b0;
        IRWrite_o  = 1'b0;
        RegDst_o   = 1'b0;
        MemtoReg_o = 1'b0;
        RegWrite_o = 1'b0;
        ALUSrcA_o  = 1'b0;
        ALUSrcB_o  = 2'b00;
        ALUOp_o    = 2'b00;
        PCSrc_o    = 2'b00;
        Illegal_o  = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite_o = 1'b1;
                ALUSrcB_o = 2'b01;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b11;
                case (Opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ORI_EN
                    OP_ORI:       state_d = S_ORIEX;
`endif
                    default: begin
                        Illegal_o = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                state_d   = (Opcode_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                IorD_o  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg_o = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_MEMWRITE: begin
                IorD_o     = 1'b1;
                MemWrite_o = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b01;
                PCSrc_o   = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: RegWrite_o = 1'b1;
            S_JUMP: begin
                PCSrc_o  = 2'b10;
                pc_write = 1'b1;
            end
`ifdef MC_ORI_EN
            S_ORIEX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALUOp_o   = 2'b11;
                state_d   = S_ORIWB;
            end
            S_ORIWB: RegWrite_o = 1'b1;
`endif
            default: state_d = S_FETCH;
        endcase

        // Reset aborts the current instruction: nothing may strobe memory, RF or PC.
        if (reset) begin
            MemWrite_o = 1'b0;
            IorD_o     = 1'b0;
            IRWrite_o  = 1'b0;
            RegDst_o   = 1'b0;
            MemtoReg_o = 1'b0;
            RegWrite_o = 1'b0;
            ALUSrcA_o  = 1'b0;
            ALUSrcB_o  = 2'b00;
            ALUOp_o    = 2'b00;
            PCSrc_o    = 2'b00;
            Illegal_o  = 1'b0;
            pc_write   = 1'b0;
            branch     = 1'b0;
        end
    end

    assign PCEn_o  = pc_write | (branch & Zero_i);
    assign State_o = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: stimulus pushes expected per-cycle
// outputs derived from instruction state paths; a negedge monitor pops and compares.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode_i;
    logic       Zero_i;
    logic       MemWrite_o, IorD_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o;
    logic       ALUSrcA_o, PCEn_o, Illegal_o;
    logic [1:0] ALUSrcB_o, ALUOp_o, PCSrc_o;
    logic [3:0] State_o;

    typedef struct packed {
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_dst;
        logic       memtoreg;
        logic       reg_write;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal;
        logic [3:0] state;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .Opcode_i(Opcode_i), .Zero_i(Zero_i),
        .MemWrite_o(MemWrite_o), .IorD_o(IorD_o), .IRWrite_o(IRWrite_o),
        .RegDst_o(RegDst_o), .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
        .PCSrc_o(PCSrc_o), .PCEn_o(PCEn_o), .Illegal_o(Illegal_o), .State_o(State_o)
    );

    // Output table of each state, straight from the control-word description.
    function automatic exp_t state_outputs(input int code, input logic zero);
        exp_t e;
        e = '0;
        e.state = code[3:0];
        case (code)
            0:  begin e.ir_write = 1; e.alusrcb = 2'b01; e.pcen = 1; end
            1:  e.alusrcb = 2'b11;
            2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            3:  e.iord = 1;
            4:  begin e.memtoreg = 1; e.reg_write = 1; end
            5:  begin e.iord = 1; e.mem_write = 1; end
            6:  begin e.alusrca = 1; e.aluop = 2'b10; end
            7:  begin e.reg_dst = 1; e.reg_write = 1; end
            8:  begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = zero; end
            9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            10: e.reg_write = 1;
            11: begin e.pcsrc = 2'b10; e.pcen = 1; end
            12: begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 2'b11; end
            13: e.reg_write = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic zero);
        int   path[$];
        bit   illegal;
        exp_t e;
        illegal = 0;
        Opcode_i = op;
        Zero_i   = zero;
        case (op)
            6'h23: path = {0, 1, 2, 3, 4};
            6'h2B: path = {0, 1, 2, 5};
            6'h00: path = {0, 1, 6, 7};
            6'h04: path = {0, 1, 8};
            6'h08: path = {0, 1, 9, 10};
            6'h02: path = {0, 1, 11};
`ifdef MC_ORI_EN
            6'h0D: path = {0, 1, 12, 13};
`endif
            default: begin path = {0, 1}; illegal = 1; end
        endcase
        foreach (path[i]) begin
            e = state_outputs(path[i], zero);
            if (i == 1) e.illegal = illegal;
            exp_q.push_back(e);
        end
        repeat (path.size()) @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int cycles);
        reset    = 1'b1;
        Zero_i   = 1'($urandom_range(0, 1));
        repeat (cycles) exp_q.push_back('0);
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // sw interrupted by reset while in MEMWRITE.
    task automatic applySwReset();
        Opcode_i = 6'h2B;
        Zero_i   = 1'b0;
        exp_q.push_back(state_outputs(0, 1'b0));
        exp_q.push_back(state_outputs(1, 1'b0));
        exp_q.push_back(state_outputs(2, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        applyReset(1);
    endtask

    task automatic checkOutput(input exp_t e);
        exp_t a;
        a = '{mem_write: MemWrite_o, iord: IorD_o, ir_write: IRWrite_o, reg_dst: RegDst_o,
              memtoreg: MemtoReg_o, reg_write: RegWrite_o, alusrca: ALUSrcA_o,
              alusrcb: ALUSrcB_o, aluop: ALUOp_o, pcsrc: PCSrc_o, pcen: PCEn_o,
              illegal: Illegal_o, state: State_o};
        checks++;
        if (a === e) passed++;
        else $display("[TB] FAIL ctrl_word t=%0t op=%h zero=%b reset=%b actual=%h (state %0d) required=%h (state %0d)",
                      $time, Opcode_i, Zero_i, reset, a, a.state, e, e.state);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        logic [5:0] legal_ops[7];
        logic [5:0] op;
        legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h0D};
        reset    = 1'b1;
        Opcode_i = 6'h23;
        Zero_i   = 1'b0;
        @(posedge clk);
        #1;
        applyReset(3);

        applyStimulus(6'h23, 1'b0);
        applyStimulus(6'h2B, 1'b1);
        applyStimulus(6'h04, 1'b1);
        applyStimulus(6'h04, 1'b0);
        applyStimulus(6'h3F, 1'b1);
        applyStimulus(6'h0D, 1'b0);
        applyStimulus(6'h00, 1'b1);
        applyStimulus(6'h08, 1'b0);
        applyStimulus(6'h02, 1'b0);
        applySwReset();
        applyStimulus(6'h23, 1'b1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 6)];
            else                          op = 6'($urandom);
            if ($urandom_range(0, 19) == 0) applyReset(int'($urandom_range(1, 2)));
            applyStimulus(op, 1'($urandom_range(0, 1)));
        end
        applySwReset();
        applyStimulus(6'h04, 1'b1);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain actual=%0d pending required=0 pending", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore-style control FSM for the multicycle MIPS datapath.
- Sits directly upstream of the unified instruction/data memory system:
  - MemWrite_o drives the memory Write_Enable_i.
  - IorD_o selects whether the memory address comes from the PC (text segment at 0x00400000) or ALUOut (data segment at 0x10100000).
- Sequences fetch, decode and execute for lw, sw, R-type, beq, addi and j.
- Drives the IR, PC, register-file and ALU strobes.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word opcode
- OP_SW, 6'h2B, store word opcode
- OP_BEQ, 6'h04, branch-equal opcode
- OP_ADDI, 6'h08, add-immediate opcode
- OP_J, 6'h02, jump opcode

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Opcode_i  input  6  IR[31:26], valid from DECODE onward
- Zero_i  input  1  ALU zero flag
- MemWrite_o  output  1  memory write enable
- IorD_o  output  1  0 = PC address, 1 = ALUOut address
- IRWrite_o  output  1  load instruction register
- RegDst_o  output  1  0 = rt, 1 = rd
- MemtoReg_o  output  1  0 = ALUOut, 1 = MDR
- RegWrite_o  output  1  register-file write
- ALUSrcA_o  output  1  0 = PC, 1 = A
- ALUSrcB_o  output  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUOp_o  output  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSrc_o  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCEn_o  output  1  PC load = PCWrite | (Branch & Zero_i)
- Illegal_o  output  1  one-cycle pulse on unsupported opcode
- State_o  output  4  current state encoding

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; clock port `clk`, reset port `reset`.
- Reset:
  - reset high at a rising edge loads state = FETCH (4'd0).
  - While reset is high, every strobe output is forced to 0 combinationally: MemWrite_o, IRWrite_o, RegWrite_o, PCEn_o, Illegal_o.
  - All mux selects read 0 during reset; State_o reads 0.
  - Reset asserted mid-instruction aborts it, with no memory or register write in that cycle.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
  - Codes 12–15 are unreachable; they return to FETCH with all strobes 0.
- Outputs are a pure function of state, except PCEn_o, which also uses Zero_i.
- Per-state outputs (unlisted strobes are 0, unlisted selects are 0):
  - FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMREAD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWRITE: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- Transitions:
  - FETCH → DECODE.
  - DECODE by Opcode_i:
    - lw or sw → MEMADR
    - R-type → EXECUTE
    - beq → BRANCH
    - addi → ADDIEX
    - j → JUMP
    - any other opcode → FETCH, with Illegal_o=1 for that DECODE cycle.
  - MEMADR: lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECUTE → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB and JUMP → FETCH.
- Opcode_i is sampled only in DECODE and MEMADR; changes in other states are ignored.
- Latency in cycles, FETCH through the last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- MemWrite_o is never high in the same cycle as IRWrite_o.
- MemWrite_o is high only in MEMWRITE, for exactly one cycle per sw.

Optional Feature:
- Macro: MC_ORI_EN.
- Defined:
  - Adds opcode 6'h0D (ori) and states ORIEX=12 and ORIWB=13.
  - DECODE → ORIEX → ORIWB → FETCH.
  - ORIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11 (or).
  - ORIWB: RegDst=0, MemtoReg=0, RegWrite=1.
- Undefined: opcode 6'h0D is illegal (Illegal_o pulse, return to FETCH); codes 12–13 are unreachable and ALUOp never takes 11.

Test Plan:
- Reset held 3 cycles then released, Opcode_i=6'h23 → while reset is high all strobes are 0. The first cycle after release has State_o=0, IRWrite_o=1, PCEn_o=1, IorD_o=0.
- lw (6'h23) → State_o sequence 0,1,2,3,4,0. IorD_o=1 in state 3. RegWrite_o=1 with MemtoReg_o=1 in state 4 only.
- sw (6'h2B) → sequence 0,1,2,5,0. MemWrite_o=1 for exactly one cycle with IorD_o=1. RegWrite_o is never 1.
- beq (6'h04), run once with Zero_i=1 and once with Zero_i=0 → sequence 0,1,8,0. In state 8, PCEn_o=1 with PCSrc_o=01 when Zero_i=1, and PCEn_o=0 when Zero_i=0.
- Opcode 6'h3F → sequence 0,1,0 with a single-cycle Illegal_o=1 in DECODE. With MC_ORI_EN defined, opcode 6'h0D → sequence 0,1,12,13,0 with ALUOp_o=11 in state 12.
- Reset asserted during state 5 (sw) → MemWrite_o drops to 0 in that cycle and State_o=0 on the next edge.
